mibench_mul_pipe: RTL

Parametrised, pipelined integer multiplier with a valid/ready handshake. It is the next-generation replacement for the fixed 16x16->16 combinational multiplier wrappers in the mibench datapath. It adds configurable operand and result widths, per-operand signedness, a configurable pipeline depth with full backpressure, and a runtime-selectable result mode: wrap, saturate, or fixed-point round-and-saturate. It sits between HLS-scheduled operand producers and result consumers wherever a multiply crosses a stall boundary.

---
 rtl/mibench_mul_pkg.sv | 39 +++
 rtl/mibench_mul_pipe_core.sv | 59 +++++
 rtl/mibench_mul_pipe.sv | 80 ++++++++
 3 files changed

// File: rtl/mibench_mul_pkg.sv
// Shared mode encodings and the result clamp used by the mibench multiplier.
// Clamp is width/domain generic up to MUL_MAX_W bits; callers pass constant width.
package mibench_mul_pkg;

   localparam logic [1:0] MUL_WRAP = 2'd0;
   localparam logic [1:0] MUL_SAT  = 2'd1;
   localparam logic [1:0] MUL_FRAC = 2'd2;

   // Widest intermediate the clamp accepts; DIN0_W+DIN1_W+2 must not exceed it.
   localparam int MUL_MAX_W = 128;

   typedef struct packed {
      logic [MUL_MAX_W-1:0] val;
      logic                 sat;
   } mul_clamp_t;

   function automatic mul_clamp_t mul_clamp(input logic signed [MUL_MAX_W-1:0] v,
                                            input int unsigned                 w,
                                            input logic                        is_signed);
      logic signed [MUL_MAX_W-1:0] one;
      logic signed [MUL_MAX_W-1:0] hi;
      logic signed [MUL_MAX_W-1:0] lo;
      mul_clamp_t                  res;
      one = {{(MUL_MAX_W-1){1'b0}}, 1'b1};
      if (is_signed) begin
         hi = (one <<< (w - 1)) - one;
         lo = -(one <<< (w - 1));
      end else begin
         hi = (one <<< w) - one;
         lo = '0;
      end
      res.sat = (v > hi) || (v < lo);
      if (v > hi)      res.val = hi;
      else if (v < lo) res.val = lo;
      else             res.val = v;
      return res;
   endfunction

endpackage

// File: rtl/mibench_mul_pipe_core.sv
// Combinational extend/multiply/round/saturate datapath; zero latency, no flow control.
// Result domain is signed when either operand is signed.
module mibench_mul_pipe_core
   import mibench_mul_pkg::*;
#(
   parameter int DIN0_W      = 16,
   parameter int DIN1_W      = 16,
   parameter int DOUT_W      = 16,
   parameter int DIN0_SIGNED = 1,
   parameter int DIN1_SIGNED = 1,
   parameter int FRAC_BITS   = 0
) (
   input  logic [DIN0_W-1:0] din0,
   input  logic [DIN1_W-1:0] din1,
   input  logic [1:0]        mode,
   output logic [DOUT_W-1:0] dout,
   output logic              sat_flag
);

   localparam int   FULL_W     = DIN0_W + DIN1_W;
   localparam int   EXT_W      = FULL_W + 1;
   localparam int   RND_W      = FULL_W + 2;
   localparam logic SGN0       = (DIN0_SIGNED != 0);
   localparam logic SGN1       = (DIN1_SIGNED != 0);
   localparam logic RES_SIGNED = SGN0 || SGN1;
   localparam int   RND_SH     = (FRAC_BITS > 0) ? FRAC_BITS - 1 : 0;
   localparam logic signed [RND_W-1:0] RND_ONE =
      (FRAC_BITS > 0) ? (RND_W'(1) << RND_SH) : '0;

   logic signed [EXT_W-1:0]     a_ext;
   logic signed [EXT_W-1:0]     b_ext;
   logic signed [EXT_W-1:0]     prod;
   logic signed [RND_W-1:0]     rnd_sum;
   logic signed [RND_W-1:0]     frac_res;
   logic signed [MUL_MAX_W-1:0] clamp_in;
   mul_clamp_t                  clamp;
   logic                        unused_clamp_hi;

   // One spare bit makes every signed/unsigned product exact; the round add gets one more.
   always_comb begin
      a_ext    = {{(EXT_W-DIN0_W){SGN0 & din0[DIN0_W-1]}}, din0};
      b_ext    = {{(EXT_W-DIN1_W){SGN1 & din1[DIN1_W-1]}}, din1};
      prod     = a_ext * b_ext;
      rnd_sum  = RND_W'(prod) + RND_ONE;
      frac_res = rnd_sum >>> FRAC_BITS;
      clamp_in = (mode == MUL_FRAC) ? MUL_MAX_W'(frac_res) : MUL_MAX_W'(prod);
      clamp    = mul_clamp(clamp_in, DOUT_W, RES_SIGNED);
      if ((mode == MUL_SAT) || (mode == MUL_FRAC)) begin
         dout     = clamp.val[DOUT_W-1:0];
         sat_flag = clamp.sat;
      end else begin
         dout     = prod[DOUT_W-1:0];
         sat_flag = 1'b0;
      end
   end

   assign unused_clamp_hi = ^clamp.val[MUL_MAX_W-1:DOUT_W];

endmodule

// File: rtl/mibench_mul_pipe.sv
// Pipelined multiplier with valid/ready; result out NUM_STAGE edges after accept.
// Stall when output held: whole pipe freezes (no bubble collapse), in_ready follows.
module mibench_mul_pipe
   import mibench_mul_pkg::*;
#(
   parameter int DIN0_W      = 16,
   parameter int DIN1_W      = 16,
   parameter int DOUT_W      = 16,
   parameter int DIN0_SIGNED = 1,
   parameter int DIN1_SIGNED = 1,
   parameter int NUM_STAGE   = 1,
   parameter int FRAC_BITS   = 0
) (
   input  logic              ap_clk,
   input  logic              ap_rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DIN0_W-1:0] din0,
   input  logic [DIN1_W-1:0] din1,
   input  logic [1:0]        mode,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DOUT_W-1:0] dout,
   output logic              sat_flag
);

   typedef struct packed {
      logic [DOUT_W-1:0] dout;
      logic              sat;
   } beat_t;

   logic [NUM_STAGE-1:0] vld_q;
   logic [NUM_STAGE-1:0] vld_d;
   beat_t                dat_q [NUM_STAGE];
   beat_t                dat_d [NUM_STAGE];
   logic [DOUT_W-1:0]    core_dout;
   logic                 core_sat;
   logic                 adv;

   mibench_mul_pipe_core #(
      .DIN0_W      (DIN0_W),
      .DIN1_W      (DIN1_W),
      .DOUT_W      (DOUT_W),
      .DIN0_SIGNED (DIN0_SIGNED),
      .DIN1_SIGNED (DIN1_SIGNED),
      .FRAC_BITS   (FRAC_BITS)
   ) u_core (
      .din0     (din0),
      .din1     (din1),
      .mode     (mode),
      .dout     (core_dout),
      .sat_flag (core_sat)
   );

   assign adv       = !vld_q[NUM_STAGE-1] || out_ready;
   assign in_ready  = adv;
   assign out_valid = vld_q[NUM_STAGE-1];
   assign dout      = dat_q[NUM_STAGE-1].dout;
   assign sat_flag  = dat_q[NUM_STAGE-1].sat;

   always_comb begin
      vld_d[0] = in_valid;
      dat_d[0] = '{dout: core_dout, sat: core_sat};
      for (int i = 1; i < NUM_STAGE; i++) begin
         vld_d[i] = vld_q[i-1];
         dat_d[i] = dat_q[i-1];
      end
   end

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         vld_q <= '0;
         for (int i = 0; i < NUM_STAGE; i++) dat_q[i] <= '0;
      end else if (adv) begin
         vld_q <= vld_d;
         dat_q <= dat_d;
      end
   end

endmodule
